// File: rtl/rca_arbiter.sv
// Two-requester arbiter/sequencer sharing one combinational ripple-carry adder.
// Optional round-robin arbitration is enabled by defining RCA_ARB_RR_EN.
module rca_arbiter #(
  parameter int NBIT       = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            R0_VALID,
  input  logic            R1_VALID,
  output logic            R0_READY,
  output logic            R1_READY,
  input  logic [NBIT-1:0] R0_A,
  input  logic [NBIT-1:0] R0_B,
  input  logic [NBIT-1:0] R1_A,
  input  logic [NBIT-1:0] R1_B,
  output logic            R0_RVALID,
  output logic            R1_RVALID,
  input  logic            R0_RACK,
  input  logic            R1_RACK,
  output logic [NBIT-1:0] RS,
  output logic [NBIT-1:0] ADD_A,
  output logic [NBIT-1:0] ADD_B,
  input  logic [NBIT-1:0] ADD_S,
  output logic            BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t          state_r;
  logic            own_r;
  logic [3:0]      cnt_r;
  logic [NBIT-1:0] rs_r;
  logic [NBIT-1:0] add_a_r;
  logic [NBIT-1:0] add_b_r;
  logic            r0_rvalid_r;
  logic            r1_rvalid_r;
  logic            busy_r;
  logic            ptr_s;
  logic            grant_vld_s;
  logic            grant_id_s;
  logic            owner_rack_s;

`ifdef RCA_ARB_RR_EN
  logic            ptr_r;
  assign ptr_s = ptr_r;
`else
  // Fixed priority: requester 0 always wins a tie.
  assign ptr_s = 1'b0;
`endif

  assign owner_rack_s = own_r ? R1_RACK : R0_RACK;

  // Grant selection, only meaningful while idle.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      if (R0_VALID && R1_VALID) begin
        grant_vld_s = 1'b1;
        grant_id_s  = ptr_s;
      end else if (R0_VALID) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (R1_VALID) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
      end
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  assign R0_READY  = grant_vld_s & ~grant_id_s;
  assign R1_READY  = grant_vld_s &  grant_id_s;
  assign R0_RVALID = r0_rvalid_r;
  assign R1_RVALID = r1_rvalid_r;
  assign RS        = rs_r;
  assign ADD_A     = add_a_r;
  assign ADD_B     = add_b_r;
  assign BUSY      = busy_r;

  // Sequencer: accept, let the ripple chain settle, capture, hold until acked.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      own_r       <= 1'b0;
      cnt_r       <= 4'd0;
      rs_r        <= '0;
      add_a_r     <= '0;
      add_b_r     <= '0;
      r0_rvalid_r <= 1'b0;
      r1_rvalid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef RCA_ARB_RR_EN
      ptr_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            if (grant_id_s) begin
              add_a_r <= R1_A;
              add_b_r <= R1_B;
            end else begin
              add_a_r <= R0_A;
              add_b_r <= R0_B;
            end
            own_r   <= grant_id_s;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == CNT_LAST) begin
            rs_r        <= ADD_S;
            r0_rvalid_r <= ~own_r;
            r1_rvalid_r <= own_r;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A RACK from the non-owner has no effect.
          if (owner_rack_s) begin
            r0_rvalid_r <= 1'b0;
            r1_rvalid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
`ifdef RCA_ARB_RR_EN
            ptr_r       <= ~own_r;
`endif
          end
        end
        default: begin
          r0_rvalid_r <= 1'b0;
          r1_rvalid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_arbiter.sv
// Self-checking bench for rca_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rca_arbiter;

  localparam int NBIT = 8;
  localparam int S    = 2;

  logic            clk;
  logic            rst;
  logic            r0_valid, r1_valid;
  logic            r0_ready, r1_ready;
  logic [NBIT-1:0] r0_a, r0_b, r1_a, r1_b;
  logic            r0_rvalid, r1_rvalid;
  logic            r0_rack, r1_rack;
  logic [NBIT-1:0] rs, add_a, add_b, add_s;
  logic            busy;

  int passed = 0;
  int total  = 0;
  int g0     = 0;
  int g1     = 0;

  // Reference model: a transaction is either absent, settling until a due
  // cycle, or presenting its result until the owner acknowledges it.
  int              cyc;
  bit              m_busy;
  bit              m_rv;
  int              m_owner;
  int              m_due;
  int              m_ptr;
  logic [NBIT-1:0] m_rs, m_add_a, m_add_b;

  rca_arbiter #(.NBIT(NBIT), .SETTLE_CYC(S)) dut (
    .CLK(clk), .RST(rst),
    .R0_VALID(r0_valid), .R1_VALID(r1_valid),
    .R0_READY(r0_ready), .R1_READY(r1_ready),
    .R0_A(r0_a), .R0_B(r0_b), .R1_A(r1_a), .R1_B(r1_b),
    .R0_RVALID(r0_rvalid), .R1_RVALID(r1_rvalid),
    .R0_RACK(r0_rack), .R1_RACK(r1_rack),
    .RS(rs), .ADD_A(add_a), .ADD_B(add_b), .ADD_S(add_s),
    .BUSY(busy)
  );

  // Stand-in for the shared combinational adder (carry discarded).
  assign add_s = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_busy = 1'b0; m_rv = 1'b0; m_owner = 0; m_due = 0; m_ptr = 0;
    m_rs = '0; m_add_a = '0; m_add_b = '0;
  endtask

  function automatic int pick(input bit v0, input bit v1, input int ptr);
    if (v0 && v1) return ptr;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    cyc++;
    if (rst) begin
      m_reset();
    end else if (!m_busy) begin
      g = pick(r0_valid, r1_valid, m_ptr);
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_owner = g;
        m_add_a = (g == 1) ? r1_a : r0_a;
        m_add_b = (g == 1) ? r1_b : r0_b;
        m_due   = cyc + S;
      end
    end else if (!m_rv) begin
      if (cyc == m_due) begin
        m_rv = 1'b1;
        m_rs = NBIT'((int'(m_add_a) + int'(m_add_b)) % (1 << NBIT));
      end
    end else if ((m_owner == 0 && r0_rack) || (m_owner == 1 && r1_rack)) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
`ifdef RCA_ARB_RR_EN
      m_ptr  = 1 - m_owner;
`endif
    end
  endtask

  task automatic check_ready();
    int g;
    g = (m_busy || rst) ? -1 : pick(r0_valid, r1_valid, m_ptr);
    chk("r0_ready", 32'(r0_ready), 32'(g == 0));
    chk("r1_ready", 32'(r1_ready), 32'(g == 1));
  endtask

  task automatic check_regs();
    chk("r0_rvalid", 32'(r0_rvalid), 32'(m_rv && m_owner == 0));
    chk("r1_rvalid", 32'(r1_rvalid), 32'(m_rv && m_owner == 1));
    chk("rs",        32'(rs),        32'(m_rs));
    chk("add_a",     32'(add_a),     32'(m_add_a));
    chk("add_b",     32'(add_b),     32'(m_add_b));
    chk("busy",      32'(busy),      32'(m_busy));
  endtask

  task automatic cycle();
    #1;
    check_ready();
    if (r0_valid && r0_ready) g0++;
    if (r1_valid && r1_ready) g1++;
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    m_reset();
    #1;
    check_regs();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    r0_valid = 1'b0; r1_valid = 1'b0; r0_rack = 1'b0; r1_rack = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    reset_dut();
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // R0 computes 2+3; R1 waits through a long un-acked response.
    r0_valid = 1'b1; r0_a = 8'd2; r0_b = 8'd3;
    #1 chk("t1_r0_ready", 32'(r0_ready), 32'd1);
    cycle();
    chk("t1_busy_after_accept", 32'(busy), 32'd1);
    r0_valid = 1'b0;
    cycle();
    chk("t1_rvalid_early", 32'(r0_rvalid), 32'd0);
    cycle();
    chk("t1_rvalid", 32'(r0_rvalid), 32'd1);
    chk("t1_rs", 32'(rs), 32'd5);
    r1_valid = 1'b1; r1_a = 8'd200; r1_b = 8'd100;
    repeat (10) begin
      cycle();
      chk("t4_hold_rs", 32'(rs), 32'd5);
      chk("t4_hold_rvalid", 32'(r0_rvalid), 32'd1);
      chk("t4_r1_ready", 32'(r1_ready), 32'd0);
    end
    r0_rack = 1'b1;
    #1 chk("rack_cycle_r1_ready", 32'(r1_ready), 32'd0);
    cycle();
    r0_rack = 1'b0;
    chk("t1_busy_after_rack", 32'(busy), 32'd0);
    #1 chk("t3_r1_ready", 32'(r1_ready), 32'd1);
    cycle();
    r1_valid = 1'b0;
    cycle();
    cycle();
    chk("t3_r1_rvalid", 32'(r1_rvalid), 32'd1);
    chk("t3_wrap_rs", 32'(rs), 32'd44);
    r1_rack = 1'b1;
    cycle();
    r1_rack = 1'b0;

    // Simultaneous requests from reset: R0 first, then R1.
    reset_dut();
    r0_valid = 1'b1; r0_a = 8'd77; r0_b = 8'd118;
    r1_valid = 1'b1; r1_a = 8'd17; r1_b = 8'd58;
    cycle();
    r0_valid = 1'b0;
    cycle();
    cycle();
    chk("t2_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("t2_rs0", 32'(rs), 32'd195);
    r0_rack = 1'b1;
    cycle();
    r0_rack = 1'b0;
    cycle();
    r1_valid = 1'b0;
    cycle();
    cycle();
    chk("t2_r1_rvalid", 32'(r1_rvalid), 32'd1);
    chk("t2_rs1", 32'(rs), 32'd75);
    r1_rack = 1'b1;
    cycle();
    r1_rack = 1'b0;

    // Reset while 7+8 is settling: result is dropped, R0 wins afterwards.
    r0_valid = 1'b1; r0_a = 8'd7; r0_b = 8'd8;
    cycle();
    r0_valid = 1'b0;
    cycle();
    rst = 1'b1;
    m_reset();
    #1;
    check_regs();
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_add_a_async", 32'(add_a), 32'd0);
    cycle();
    cycle();
    chk("t5_no_rvalid", 32'(r0_rvalid), 32'd0);
    rst = 1'b0;
    r0_valid = 1'b1; r0_a = 8'd1; r0_b = 8'd1;
    r1_valid = 1'b1; r1_a = 8'd2; r1_b = 8'd2;
    #1 chk("t5_r0_wins", 32'(r0_ready), 32'd1);
    cycle();
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rack = 1'b1;
    repeat (S + 2) cycle();
    r0_rack = 1'b0;

    // Both held valid with immediate acks for three transaction slots.
    reset_dut();
    g0 = 0; g1 = 0;
    r0_valid = 1'b1; r1_valid = 1'b1; r0_rack = 1'b1; r1_rack = 1'b1;
    repeat (3 * (S + 2)) cycle();
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (S + 2) cycle();
    r0_rack = 1'b0; r1_rack = 1'b0;
`ifdef RCA_ARB_RR_EN
    chk("t6_r0_grants", 32'(g0), 32'd2);
    chk("t6_r1_grants", 32'(g1), 32'd1);
`else
    chk("t6_r0_grants", 32'(g0), 32'd3);
    chk("t6_r1_grants", 32'(g1), 32'd0);
`endif

    // Randomized traffic against the model.
    repeat (1500) begin
      r0_valid = ($urandom_range(0, 1) == 1);
      r1_valid = ($urandom_range(0, 1) == 1);
      r0_rack  = ($urandom_range(0, 2) == 0);
      r1_rack  = ($urandom_range(0, 2) == 0);
      r0_a = NBIT'($urandom); r0_b = NBIT'($urandom);
      r1_a = NBIT'($urandom); r1_b = NBIT'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rca_arbiter.md
# rca_arbiter

Two-requester arbiter and sequencer for one shared `decomposed_rca` combinational adder.
- Grants one requester at a time and registers its operands onto the adder inputs.
- Waits a fixed number of cycles for the ripple chain to settle, then captures the sum and holds it until the owner acknowledges it.
- Sits between the adder instance and client logic, so one NBIT adder serves two datapaths.

## Interface
Parameters:
- `NBIT`, 8 (from `constants.v`): operand/sum width, must match the adder instance.
- `SETTLE_CYC`, 2: cycles operands are held before the sum is sampled; legal range 1..15.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `R0_VALID`, `R1_VALID`  in  1  request present.
- `R0_READY`, `R1_READY`  out  1  request accepted this cycle when VALID && READY.
- `R0_A`, `R0_B`, `R1_A`, `R1_B`  in  NBIT  operands.
- `R0_RVALID`, `R1_RVALID`  out  1  result valid for that requester.
- `R0_RACK`, `R1_RACK`  in  1  result consumed.
- `RS`  out  NBIT  registered result, shared by both requesters.
- `ADD_A`, `ADD_B`  out  NBIT  registered operands to the adder `A`/`B`.
- `ADD_S`  in  NBIT  adder `S`.
- `BUSY`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, SETTLE, RESP. Owner register `OWN` (0/1). Priority pointer `PTR` (0/1). Counter `CNT` (4 bits).
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to requester `PTR`.
  - Only the granted requester sees READY=1, combinationally.
  - On accept: latch its A/B into `ADD_A`/`ADD_B`, set OWN, set CNT=0, go to SETTLE.
- SETTLE:
  - READY=0 on both ports; `ADD_A`/`ADD_B` held stable.
  - CNT increments each edge.
  - On the edge where CNT==SETTLE_CYC-1: capture `ADD_S` into RS and go to RESP.
- RESP:
  - Rn_RVALID=1 for n==OWN only; RS is held.
  - On the edge with the owner's RACK=1: go to IDLE and set PTR=~OWN.
  - A RACK from the non-owner is ignored.
- Arithmetic: RS = (A+B) mod 2^NBIT. The carry-out is discarded, because the adder has no carry port.
- RVALID stays high and RS stays stable until RACK, for any number of cycles.

## Timing
- Reset values: READY=0/0, RVALID=0/0, RS=0, ADD_A=0, ADD_B=0, BUSY=0, state IDLE, PTR=0, OWN=0, CNT=0.
- Latency: for an accept at edge k, RVALID rises after edge k+SETTLE_CYC.
- Throughput: one transaction per SETTLE_CYC+2 cycles minimum, because one IDLE cycle separates transactions.
- Boundary conditions:
  - RACK together with a new VALID: the new request is not accepted in the RESP cycle. It can be accepted in the following IDLE cycle.
  - A VALID dropped before accept is legal and is simply not granted.
  - RST asserted mid-SETTLE or mid-RESP: all outputs go to reset values immediately. The in-flight result is lost and no RVALID is issued for it.
  - SETTLE_CYC=1: capture occurs on the first edge after accept.

## Configuration
- `RCA_ARB_RR_EN` defined: round-robin arbitration as above; PTR toggles to the other requester after each completed transaction.
- `RCA_ARB_RR_EN` undefined: fixed priority, requester 0 always wins ties. PTR is constant 0 and R1 can be starved.

## Test plan
All cases use NBIT=8, SETTLE_CYC=2, with `RCA_ARB_RR_EN` defined unless stated.
- R0 requests 2+3: R0_READY=1 in the accept cycle, R0_RVALID=1 two cycles later, RS=5, BUSY=1 from the accept edge until the RACK edge.
- R0 (77+118) and R1 (17+58) valid in the same cycle from reset: R0 is served first with RS=195; after R0_RACK, R1 is served with RS=75.
- Wrap: R1 requests 200+100 → RS=44, no carry indication.
- Hold R0_RACK low for 10 cycles after RVALID: R0_RVALID and RS=5 stay stable; R1_VALID=1 during this time gets R1_READY=0 throughout.
- Assert RST one cycle after accepting 7+8: all outputs return to zero asynchronously, no RVALID is issued, and the next request after RST release is granted to R0.
- With `RCA_ARB_RR_EN` undefined, both requesters held valid for 3 transactions: all 3 grants go to R0, R1_READY stays 0.
